// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the parametrised register file.
// Holds the clear-FSM state enum, the address-width helper and default sizes.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // ceil(log2(n)); constant-foldable for parameter use
  function automatic int aw_of(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: clear sequencer, walks the array writing zero one entry/cycle.
// Ports: clk, rst (async low), clr_req in; busy, clr_done, clr_we, clr_addr out.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = aw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_nx;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    busy       = 1'b0;
    clr_done   = 1'b0;
    clr_we     = 1'b0;
    clr_addr   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nx = CLEAR;
          w_cnt_nx   = '0;
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        clr_we   = 1'b1;
        // counter wraps to 0 on the last entry, no extra cycle
        w_cnt_nx = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          clr_done   = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_np.sv
// regfile_np: parametrised register file, NRD comb read ports, 1 write port.
// Ports: clk, rst (async low), clr_req/busy/clr_done, we/wa/wd, ra/rd (packed).
module regfile_np
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NRD      = NRD_DEF,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 0,
  localparam int AW       = aw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd
);

  logic [XLEN-1:0] r_mem [DEPTH];

  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic          w_wa_zero;
  logic          w_ext_we;

  regfile_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_done (clr_done),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign busy      = w_busy;
  assign w_wa_zero = (ZERO_REG != 0) && (wa == '0);

  // a write in the cycle a clear is requested loses to the clear
  assign w_ext_we = we && !w_busy && !clr_req && !w_wa_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_ext_we) begin
      r_mem[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;

    assign w_ra = ra[g*AW +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && w_ext_we && (wa == w_ra)) begin
        // only writes that will actually land are forwarded
        w_rd = wd;
      end
      if (!rst || w_busy) begin
        w_rd = '0;
      end
    end

    assign rd[g*XLEN +: XLEN] = w_rd;
  end

endmodule

// File: tb/tb_regfile_np.sv
// tb_regfile_np: three configurations driven by one stimulus stream and
// checked every cycle against an array-based model, plus literal checks.
module tb_regfile_np;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [63:0] wd = '0;
  logic [4:0]  ra_v [3];

  logic         u0_busy, u0_done, u1_busy, u1_done, u2_busy, u2_done;
  logic [63:0]  u0_rd, u1_rd;
  logic [191:0] u2_rd;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  regfile_np #(.XLEN(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(u0_busy),
    .clr_done(u0_done), .we(we), .wa(wa), .wd(wd[31:0]),
    .ra({ra_v[1], ra_v[0]}), .rd(u0_rd)
  );

  regfile_np #(.XLEN(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(u1_busy),
    .clr_done(u1_done), .we(we), .wa(wa), .wd(wd[31:0]),
    .ra({ra_v[1], ra_v[0]}), .rd(u1_rd)
  );

  regfile_np #(.XLEN(64), .DEPTH(16), .NRD(3), .ZERO_REG(1), .BYPASS(0)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(u2_busy),
    .clr_done(u2_done), .we(we), .wa(wa[3:0]), .wd(wd),
    .ra({ra_v[2][3:0], ra_v[1][3:0], ra_v[0][3:0]}), .rd(u2_rd)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, got, exp);
  endtask

  function automatic logic [63:0] dut_rd(input int k, input int i);
    case (k)
      0:       return {32'b0, u0_rd[i*32 +: 32]};
      1:       return {32'b0, u1_rd[i*32 +: 32]};
      default: return u2_rd[i*64 +: 64];
    endcase
  endfunction

  function automatic logic dut_busy(input int k);
    case (k)
      0:       return u0_busy;
      1:       return u1_busy;
      default: return u2_busy;
    endcase
  endfunction

  function automatic logic dut_done(input int k);
    case (k)
      0:       return u0_done;
      1:       return u1_done;
      default: return u2_done;
    endcase
  endfunction

  // model: per-configuration array, clear progress as a plain index
  int          c_depth [3] = '{32, 32, 16};
  int          c_nrd   [3] = '{2, 2, 3};
  bit          c_byp   [3] = '{1'b0, 1'b1, 1'b0};
  logic [63:0] c_mask  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, '1};
  logic [63:0] m_mem [3][32];
  bit          m_busy [3];
  int          m_pos  [3];

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0;
      m_pos[k]  = 0;
      for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
    end
  endtask

  task automatic m_check();
    int a, w;
    logic [63:0] e;
    if (!rst) m_reset();
    for (int k = 0; k < 3; k++) begin
      w = int'(wa) % c_depth[k];
      chk($sformatf("busy_u%0d", k), 64'(dut_busy(k)), 64'(m_busy[k]));
      chk($sformatf("done_u%0d", k), 64'(dut_done(k)),
          64'(m_busy[k] && m_pos[k] == c_depth[k] - 1));
      for (int i = 0; i < c_nrd[k]; i++) begin
        a = int'(ra_v[i]) % c_depth[k];
        if (!rst || m_busy[k] || a == 0) e = '0;
        else if (c_byp[k] && we && !clr_req && w == a) e = wd & c_mask[k];
        else e = m_mem[k][a];
        chk($sformatf("rd_u%0d_p%0d_a%0d", k, i, a), dut_rd(k, i), e);
      end
    end
  endtask

  task automatic m_step();
    int w;
    for (int k = 0; k < 3; k++) begin
      w = int'(wa) % c_depth[k];
      if (!rst) begin
        m_busy[k] = 1'b0;
        for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
      end else if (m_busy[k]) begin
        m_mem[k][m_pos[k]] = '0;
        m_pos[k]++;
        if (m_pos[k] == c_depth[k]) m_busy[k] = 1'b0;
      end else if (clr_req) begin
        m_busy[k] = 1'b1;
        m_pos[k]  = 0;
      end else if (we && w != 0) begin
        m_mem[k][w] = wd & c_mask[k];
      end
    end
  endtask

  initial m_reset();

  always begin
    @(negedge clk);
    #2;
    m_check();
    @(posedge clk);
    m_step();
  end

  int c0, d0, c2, d2;

  initial begin
    ra_v = '{default: '0};
    repeat (3) @(negedge clk);
    #3 chk("rst_rd0", dut_rd(0, 0), 64'h0);

    @(negedge clk);
    rst = 1'b1; ra_v[0] = 5; ra_v[1] = 6;
    #3 chk("post_rst_rd0", dut_rd(0, 0), 64'h0);
    chk("post_rst_rd1", dut_rd(0, 1), 64'h0);

    @(negedge clk);
    we = 1'b1; wa = 7; wd = 64'hDEAD_BEEF; ra_v[0] = 7;
    #3 chk("byp_same_cycle", dut_rd(1, 0), 64'hDEAD_BEEF);
    chk("nobyp_same_cycle", dut_rd(0, 0), 64'h0);
    @(negedge clk);
    we = 1'b0;
    #3 chk("wr7_u0", dut_rd(0, 0), 64'hDEAD_BEEF);
    chk("wr7_u2", dut_rd(2, 0), 64'hDEAD_BEEF);

    @(negedge clk);
    we = 1'b1; wa = 0; wd = 64'h1234; ra_v[1] = 0;
    @(negedge clk);
    we = 1'b0;
    #3 chk("zero_reg", dut_rd(0, 1), 64'h0);

    @(negedge clk);
    we = 1'b1; wa = 3; wd = 64'hA5A5_A5A5; ra_v[0] = 3;
    #3 chk("byp_a5", dut_rd(1, 0), 64'hA5A5_A5A5);
    chk("nobyp_old", dut_rd(0, 0), 64'h0);

    @(negedge clk);
    wa = 9; wd = 64'h0123_4567_89AB_CDEF;
    ra_v[0] = 9; ra_v[1] = 7; ra_v[2] = 3;
    @(negedge clk);
    we = 1'b0;
    #3 chk("wide_p0", dut_rd(2, 0), 64'h0123_4567_89AB_CDEF);
    chk("wide_p1", dut_rd(2, 1), 64'hDEAD_BEEF);
    chk("wide_p2", dut_rd(2, 2), 64'hA5A5_A5A5);
    chk("narrow_trunc", dut_rd(0, 0), 64'h89AB_CDEF);

    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; wa = 5'(i); wd = 64'(i);
    end
    @(negedge clk);
    we = 1'b0; ra_v[0] = 17;
    #3 chk("preload17_u0", dut_rd(0, 0), 64'd17);
    chk("preload17_u2", dut_rd(2, 0), 64'd17);

    @(negedge clk);
    clr_req = 1'b1; we = 1'b1; wa = 5; wd = '1; ra_v[0] = 5;
    #3 chk("collide_nofwd", dut_rd(1, 0), 64'd5);
    c0 = 0; d0 = 0; c2 = 0; d2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      clr_req = 1'b0;
      we = (i <= 32) ? 1'($urandom) : 1'b0;
      wa = 5'($urandom); wd = {$urandom, $urandom};
      ra_v[0] = 5'($urandom); ra_v[1] = 5'($urandom);
      #3;
      if (u0_busy) c0++;
      if (u0_done) d0 = i;
      if (u2_busy) c2++;
      if (u2_done) d2 = i;
    end
    chk("busy_len_u0", 64'(c0), 64'd32);
    chk("done_at_u0", 64'(d0), 64'd32);
    chk("busy_len_u2", 64'(c2), 64'd16);
    chk("done_at_u2", 64'(d2), 64'd16);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      ra_v[0] = 5'(a);
      #3 chk($sformatf("cleared_%0d", a), dut_rd(0, 0), 64'h0);
    end

    for (int i = 15; i <= 25; i++) begin
      @(negedge clk);
      we = 1'b1; wa = 5'(i); wd = 64'(i * 3);
    end
    @(negedge clk);
    we = 1'b0; clr_req = 1'b1; ra_v[0] = 20;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      clr_req = 1'b0;
      if (i == 10) rst = 1'b0;
    end
    #3 chk("abort_busy", 64'(u0_busy), 64'h0);
    chk("abort_rd", dut_rd(0, 0), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #3 chk("abort_entry20", dut_rd(0, 0), 64'h0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) != 0);
      clr_req = ($urandom_range(0, 59) == 0);
      we      = 1'($urandom);
      wa      = 5'($urandom);
      wd      = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) ra_v[i] = 5'($urandom);
    end
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
